// File: rtl/scan_mux_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_nx1
//  Description : Registered N-channel, W-bit multiplexer with a select
//                register that is either loaded manually or advanced as a
//                round-robin scan. The selected channel is captured into a
//                registered output stage together with its channel index and
//                a valid flag.
//
//  Ports
//    clk         in   1               rising-edge clock
//    rst         in   1               asynchronous active-high reset
//    data_in     in   CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH]
//    sel_in      in   SEL_W           manual channel index
//    sel_load    in   1               load sel_in into the select register
//    mode        in   1               0 = manual, 1 = scan
//    enable      in   1               sample selected channel, advance scan
//    dout        out  WIDTH           registered selected data
//    dout_ch     out  SEL_W           channel index that produced dout
//    dout_valid  out  1               dout/dout_ch updated this cycle
//    wrap        out  1               pulse with the sample of the last channel
//    sel_err     out  1               pulse after an out-of-range sel_in load
//
//  Revision    : 1.0  initial release
// ============================================================================
module scan_mux_nx1 #(
   parameter int WIDTH    = 2,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      sel_load,
   input  logic                      mode,
   input  logic                      enable,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          dout_ch,
   output logic                      dout_valid,
   output logic                      wrap,
   output logic                      sel_err
);

   // The mux is built over every code the select register could encode.
   // Codes at or above CHANNELS are tied to zero; sel never holds them, the
   // padding only keeps the index range clean for non-power-of-two counts.
   localparam int                NUM_SLOTS = 1 << SEL_W;
   localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W:0]    NUM_CH    = (SEL_W + 1)'(CHANNELS);

   logic [WIDTH-1:0] slot [NUM_SLOTS];

   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] sel_next;
   logic             sel_in_ok;
   logic             load_ok;
   logic             load_bad;
   logic             advance;
   logic             at_last;

   genvar k;
   generate
      for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
         if (k < CHANNELS) begin : g_used
            assign slot[k] = data_in[k*WIDTH +: WIDTH];
         end else begin : g_pad
            assign slot[k] = '0;
         end
      end
   endgenerate

   // One extra bit on the compare so CHANNELS == 2**SEL_W is representable.
   assign sel_in_ok = ({1'b0, sel_in} < NUM_CH);
   assign load_ok   = sel_load &  sel_in_ok;
   assign load_bad  = sel_load & ~sel_in_ok;

   // Any load request, valid or not, suppresses the scan step for that cycle.
   assign advance   = ~sel_load & mode & enable;
   assign at_last   = (sel == LAST_CH);

   always_comb begin
      sel_next = sel;
      if (load_ok) begin
         sel_next = sel_in;
      end else if (advance) begin
         sel_next = at_last ? '0 : sel + 1'b1;
      end
   end

   // Output stage samples with the select value in force before this edge,
   // so a load or scan step only affects the following sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel        <= '0;
         dout       <= '0;
         dout_ch    <= '0;
         dout_valid <= 1'b0;
         wrap       <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         sel        <= sel_next;
         dout_valid <= enable;
         wrap       <= advance & at_last;
         sel_err    <= load_bad;
         if (enable) begin
            dout    <= slot[sel];
            dout_ch <= sel;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scan_mux_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_mux_nx1
//  Description : Self-checking bench for scan_mux_nx1. Two instances are
//                exercised: the default 4 x 2-bit configuration and a
//                5 x 4-bit non-power-of-two configuration. A channel-index
//                model predicts every output each cycle; directed literal
//                expectations pin key points of the sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_mux_nx1;

   logic clk;
   logic rst;

   // Instance A: CHANNELS=4, WIDTH=2
   logic [7:0]  a_data;
   logic [1:0]  a_sel;
   logic        a_ld, a_mode, a_en;
   logic [1:0]  a_dout;
   logic [1:0]  a_ch;
   logic        a_valid, a_wrap, a_err;

   // Instance B: CHANNELS=5, WIDTH=4
   logic [19:0] b_data;
   logic [2:0]  b_sel;
   logic        b_ld, b_mode, b_en;
   logic [3:0]  b_dout;
   logic [2:0]  b_ch;
   logic        b_valid, b_wrap, b_err;

   int checks   = 0;
   int failures = 0;

   scan_mux_nx1 dut_a (
      .clk(clk), .rst(rst), .data_in(a_data), .sel_in(a_sel),
      .sel_load(a_ld), .mode(a_mode), .enable(a_en),
      .dout(a_dout), .dout_ch(a_ch), .dout_valid(a_valid),
      .wrap(a_wrap), .sel_err(a_err)
   );

   scan_mux_nx1 #(.WIDTH(4), .CHANNELS(5)) dut_b (
      .clk(clk), .rst(rst), .data_in(b_data), .sel_in(b_sel),
      .sel_load(b_ld), .mode(b_mode), .enable(b_en),
      .dout(b_dout), .dout_ch(b_ch), .dout_valid(b_valid),
      .wrap(b_wrap), .sel_err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (channel index as an integer) ------
   int          m_pos   [2] = '{0, 0};
   logic [31:0] e_dout  [2] = '{0, 0};
   int          e_ch    [2] = '{0, 0};
   bit          e_valid [2] = '{0, 0};
   bit          e_wrap  [2] = '{0, 0};
   bit          e_err   [2] = '{0, 0};

   task automatic model_step(input int i, input int nch, input int w,
                             input logic [31:0] d, input int si,
                             input bit ld, input bit md, input bit en);
      if (en) begin
         e_dout[i] = (d >> (m_pos[i] * w)) & ((32'd1 << w) - 32'd1);
         e_ch[i]   = m_pos[i];
      end
      e_valid[i] = en;
      e_wrap[i]  = 1'b0;
      e_err[i]   = 1'b0;
      if (ld) begin
         if (si < nch) m_pos[i] = si;
         else          e_err[i] = 1'b1;
      end else if (md && en) begin
         if (m_pos[i] + 1 == nch) e_wrap[i] = 1'b1;
         m_pos[i] = (m_pos[i] + 1) % nch;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; e_dout[i] = 0; e_ch[i] = 0;
            e_valid[i] = 0; e_wrap[i] = 0; e_err[i] = 0;
         end
      end else begin
         model_step(0, 4, 2, {24'b0, a_data}, int'(a_sel), a_ld, a_mode, a_en);
         model_step(1, 5, 4, {12'b0, b_data}, int'(b_sel), b_ld, b_mode, b_en);
      end
   end

   // Compare every cycle, half a period after the active edge.
   initial forever begin
      @(negedge clk);
      chk("a_dout",  {30'b0, a_dout},  e_dout[0]);
      chk("a_ch",    {30'b0, a_ch},    e_ch[0]);
      chk("a_valid", {31'b0, a_valid}, {31'b0, e_valid[0]});
      chk("a_wrap",  {31'b0, a_wrap},  {31'b0, e_wrap[0]});
      chk("a_err",   {31'b0, a_err},   {31'b0, e_err[0]});
      chk("b_dout",  {28'b0, b_dout},  e_dout[1]);
      chk("b_ch",    {29'b0, b_ch},    e_ch[1]);
      chk("b_valid", {31'b0, b_valid}, {31'b0, e_valid[1]});
      chk("b_wrap",  {31'b0, b_wrap},  {31'b0, e_wrap[1]});
      chk("b_err",   {31'b0, b_err},   {31'b0, e_err[1]});
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- directed stimulus with literal expectations ----------
   int a_ch_exp [7] = '{0, 1, 2, 3, 0, 1, 2};
   int b_ch_exp [7] = '{0, 1, 2, 3, 4, 0, 1};

   initial begin
      rst    = 1'b1;
      a_data = 8'($urandom);  a_sel = 2'd0; a_ld = 0; a_mode = 0; a_en = 0;
      b_data = 20'($urandom); b_sel = 3'd0; b_ld = 0; b_mode = 0; b_en = 0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_a_dout",  {30'b0, a_dout}, 32'd0);
      chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
      chk("rst_b_ch",    {29'b0, b_ch},   32'd0);

      // Scan sweep on both instances
      a_data = 8'b11_10_01_00; a_mode = 1; a_en = 1;
      b_data = 20'h97531;      b_mode = 1; b_en = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("scan_a_ch",   {30'b0, a_ch},   32'(a_ch_exp[i]));
         chk("scan_a_dout", {30'b0, a_dout}, 32'(a_ch_exp[i]));
         chk("scan_a_wrap", {31'b0, a_wrap}, (i == 3) ? 32'd1 : 32'd0);
         chk("scan_b_ch",   {29'b0, b_ch},   32'(b_ch_exp[i]));
         chk("scan_b_dout", {28'b0, b_dout}, 32'(2 * b_ch_exp[i] + 1));
         chk("scan_b_wrap", {31'b0, b_wrap}, (i == 4) ? 32'd1 : 32'd0);
      end

      // A pauses for 3 cycles; B presents an out-of-range load
      a_en = 0; b_ld = 1; b_sel = 3'd6;
      tick();
      chk("err_b_pulse", {31'b0, b_err},   32'd1);
      chk("err_b_ch",    {29'b0, b_ch},    32'd2);
      chk("pause_a_val", {31'b0, a_valid}, 32'd0);
      chk("pause_a_hold",{30'b0, a_dout},  32'd2);
      b_ld = 0;
      tick();
      chk("err_b_clear", {31'b0, b_err}, 32'd0);
      chk("err_b_noadv", {29'b0, b_ch},  32'd2);
      b_en = 0;
      tick();
      chk("pause_a_ch",  {30'b0, a_ch},  32'd2);
      a_en = 1;
      tick();
      chk("resume_a_ch",   {30'b0, a_ch},   32'd3);
      chk("resume_a_wrap", {31'b0, a_wrap}, 32'd1);
      tick();
      tick();
      chk("scan_a_ch1", {30'b0, a_ch}, 32'd1);

      // Load while scanning: current sample first, loaded channel next
      a_ld = 1; a_sel = 2'd0;
      tick();
      chk("prio_a_ch_now", {30'b0, a_ch}, 32'd2);
      a_ld = 0;
      tick();
      chk("prio_a_ch_ld",  {30'b0, a_ch}, 32'd0);
      tick();
      chk("prio_a_ch_nx",  {30'b0, a_ch}, 32'd1);

      // Manual mode: repeated sampling of one channel
      a_mode = 0; a_ld = 1; a_sel = 2'd2;
      tick();
      a_ld = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("man_a_dout",  {30'b0, a_dout},  32'd2);
         chk("man_a_valid", {31'b0, a_valid}, 32'd1);
      end
      a_ld = 1; a_sel = 2'd3;
      tick();
      chk("man_a_ld_old", {30'b0, a_dout}, 32'd2);
      a_ld = 0;
      tick();
      chk("man_a_ld_new", {30'b0, a_dout}, 32'd3);

      // Async reset while scanning with sel at 3
      a_mode = 1; a_ld = 1; a_sel = 2'd2; a_en = 0;
      tick();
      a_ld = 0; a_en = 1;
      tick();
      chk("pre_rst_a_ch", {30'b0, a_ch}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_a_dout",  {30'b0, a_dout},  32'd0);
      chk("arst_a_ch",    {30'b0, a_ch},    32'd0);
      chk("arst_a_valid", {31'b0, a_valid}, 32'd0);
      chk("arst_b_dout",  {28'b0, b_dout},  32'd0);
      chk("arst_b_ch",    {29'b0, b_ch},    32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_a_ch",    {30'b0, a_ch},    32'd0);
      chk("post_rst_a_valid", {31'b0, a_valid}, 32'd1);
      tick();
      chk("post_rst_a_ch1",   {30'b0, a_ch},    32'd1);
      chk("post_rst_a_dout1", {30'b0, a_dout},  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
